// File: rtl/digest_stream_tx.sv
// Captures one hash digest word and streams its mode-dependent byte length over AXI-Stream.
// Optional build macro DIGEST_STREAM_TX_BSWAP_EN selects little-endian lane order within a beat.
module digest_stream_tx #(
   parameter int unsigned DW = 1344,
   parameter int unsigned OW = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      algo_mode,
   input  logic [DW-1:0]   din,
   input  logic            din_valid,
   output logic            din_ready,
   output logic            m_tvalid,
   input  logic            m_tready,
   output logic [OW-1:0]   m_tdata,
   output logic [OW/8-1:0] m_tkeep,
   output logic            m_tlast,
   output logic            busy,
   output logic            drop_err,
   output logic            mode_err,
   input  logic            clr_err
);

   localparam int unsigned KW = OW / 8;

   typedef enum logic [0:0] {StIdle, StSend} state_t;

   state_t        state;
   logic [DW-1:0] shift_buf;
   logic [4:0]    beat_idx;
   logic [4:0]    beat_last;
   logic [2:0]    tail_bytes;

   logic [4:0]    dec_beats;
   logic [2:0]    dec_tail;
   logic          dec_legal;
   logic          hs;
   logic          capture;

   // Beat count is ceil(N/8); dec_tail is N mod 8 (0 means the last beat is full).
   always_comb begin
      dec_beats = 5'd0;
      dec_tail  = 3'd0;
      dec_legal = 1'b1;
      if (!algo_mode[3]) begin
         dec_beats = algo_mode[0] ? 5'd8 : 5'd4;
      end else begin
         case (algo_mode[2:0])
            3'h0: dec_beats = 5'd21;
            3'h1: dec_beats = 5'd17;
            3'h2: dec_beats = 5'd4;
            3'h3: dec_beats = 5'd8;
            3'h4: begin
               dec_beats = 5'd4;
               dec_tail  = 3'd4;
            end
            3'h5: dec_beats = 5'd6;
            default: dec_legal = 1'b0;
         endcase
      end
   end

   assign hs        = m_tvalid & m_tready;
   assign din_ready = (state == StIdle) | (hs & m_tlast);
   assign capture   = din_valid & din_ready & dec_legal;
   assign busy      = (state == StSend);

   // Returns {keep, data} for one beat; lanes beyond the digest length are zeroed.
   function automatic logic [KW+OW-1:0] fmt_beat(input logic [OW-1:0] raw, input logic last,
                                                input logic [2:0] tail);
      logic [OW-1:0] data;
      logic [KW-1:0] keep;
      data = raw;
      keep = {KW{1'b1}};
`ifdef DIGEST_STREAM_TX_BSWAP_EN
      for (int i = 0; i < int'(KW); i++) begin
         data[8*i +: 8] = raw[OW-8-8*i +: 8];
      end
      if (last && tail != 3'd0) keep = {KW{1'b1}} >> (KW - 32'(tail));
`else
      if (last && tail != 3'd0) keep = ~({KW{1'b1}} >> tail);
`endif
      for (int i = 0; i < int'(KW); i++) begin
         if (!keep[i]) data[8*i +: 8] = 8'h00;
      end
      return {keep, data};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         m_tvalid   <= 1'b0;
         m_tlast    <= 1'b0;
         m_tkeep    <= '0;
         m_tdata    <= '0;
         beat_idx   <= '0;
         beat_last  <= '0;
         tail_bytes <= '0;
         shift_buf  <= '0;
         drop_err   <= 1'b0;
         mode_err   <= 1'b0;
      end else begin
         drop_err <= (din_valid & ~din_ready) | (drop_err & ~clr_err);
         mode_err <= (din_valid & din_ready & ~dec_legal) | (mode_err & ~clr_err);
         if (capture) begin
            state      <= StSend;
            m_tvalid   <= 1'b1;
            beat_idx   <= 5'd0;
            beat_last  <= dec_beats - 5'd1;
            tail_bytes <= dec_tail;
            m_tlast    <= (dec_beats == 5'd1);
            {m_tkeep, m_tdata} <= fmt_beat(din[DW-1 -: OW], dec_beats == 5'd1, dec_tail);
            shift_buf  <= {din[DW-OW-1:0], {OW{1'b0}}};
         end else if (hs) begin
            if (m_tlast) begin
               state    <= StIdle;
               m_tvalid <= 1'b0;
               m_tlast  <= 1'b0;
               m_tkeep  <= '0;
               m_tdata  <= '0;
            end else begin
               beat_idx  <= beat_idx + 5'd1;
               m_tlast   <= (beat_idx + 5'd1 == beat_last);
               {m_tkeep, m_tdata} <= fmt_beat(shift_buf[DW-1 -: OW], beat_idx + 5'd1 == beat_last,
                                              tail_bytes);
               shift_buf <= {shift_buf[DW-OW-1:0], {OW{1'b0}}};
            end
         end
      end
   end

endmodule

// File: tb/tb_digest_stream_tx.sv
// Self-checking bench for digest_stream_tx: byte-level reference model, randomized digests and
// backpressure, plus directed error and reset scenarios.
module tb_digest_stream_tx;
   localparam int DW = 1344;
   typedef logic [72:0] beat_t;  // {last, keep, data}

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    algo_mode = 4'h0;
   logic [DW-1:0] din = '0;
   logic          din_valid = 1'b0;
   logic          din_ready;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic [63:0]   m_tdata;
   logic [7:0]    m_tkeep;
   logic          m_tlast;
   logic          busy;
   logic          drop_err;
   logic          mode_err;
   logic          clr_err = 1'b0;

   always #5 clk = ~clk;

   digest_stream_tx #(.DW(DW), .OW(64)) dut (
      .clk(clk), .rst(rst), .algo_mode(algo_mode), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
      .m_tkeep(m_tkeep), .m_tlast(m_tlast), .busy(busy), .drop_err(drop_err),
      .mode_err(mode_err), .clr_err(clr_err)
   );

   int    pass_cnt = 0;
   int    total_cnt = 0;
   int    cyc = 0;
   int    stab_viol = 0;
   int    ready_mode = 0;  // 0 always, 1 toggle, 2 random, 3 held low
   beat_t rx_q[$];
   beat_t exp_q[$];
   int    rx_cyc[$];
   logic  s_ready;
   logic  prev_stall = 1'b0;
   beat_t prev_beat = '0;

   function automatic int mode_len(input logic [3:0] m);
      case (m)
         4'h0, 4'h2, 4'h4, 4'h6: return 32;
         4'h1, 4'h3, 4'h5, 4'h7: return 64;
         4'h8: return 168;
         4'h9: return 136;
         4'hA: return 32;
         4'hB: return 64;
         4'hC: return 28;
         4'hD: return 48;
         default: return 0;
      endcase
   endfunction

   // Byte j of the digest is din[DW-1-8j -: 8]; beat k carries bytes 8k..8k+7.
   function automatic void push_exp(input logic [DW-1:0] d, input logic [3:0] m);
      int n;
      logic [63:0] data;
      logic [7:0] keep;
      int j;
      n = mode_len(m);
      for (int k = 0; k * 8 < n; k++) begin
         data = '0;
         keep = '0;
         for (int i = 0; i < 8; i++) begin
            j = 8 * k + i;
            if (j < n) begin
`ifdef DIGEST_STREAM_TX_BSWAP_EN
               data[8*i +: 8] = d[DW-1-8*j -: 8];
               keep[i] = 1'b1;
`else
               data[63-8*i -: 8] = d[DW-1-8*j -: 8];
               keep[7-i] = 1'b1;
`endif
            end
         end
         exp_q.push_back({((k + 1) * 8 >= n), keep, data});
      end
   endfunction

   function automatic logic [DW-1:0] rand_digest();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   function automatic void clear_q();
      rx_q.delete();
      rx_cyc.delete();
      exp_q.delete();
   endfunction

   // One clock: sample at negedge, then advance to 1 ns past the next posedge.
   task automatic step();
      beat_t cur;
      @(negedge clk);
      cur = {m_tlast, m_tkeep, m_tdata};
      s_ready = din_ready;
      if (prev_stall && !(m_tvalid === 1'b1 && cur === prev_beat)) stab_viol++;
      if (m_tvalid === 1'b1 && m_tready === 1'b1 && !rst) begin
         rx_q.push_back(cur);
         rx_cyc.push_back(cyc);
      end
      prev_stall = (m_tvalid === 1'b1) && !m_tready && !rst;
      prev_beat = cur;
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
         0: m_tready = 1'b1;
         1: m_tready = ~m_tready;
         2: m_tready = ($urandom_range(0, 3) != 0);
         default: m_tready = 1'b0;
      endcase
   endtask

   task automatic capture(input logic [DW-1:0] d, input logic [3:0] m);
      din = d;
      algo_mode = m;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (rx_q.size() < exp_q.size() && n < budget) begin
         step();
         n++;
      end
      repeat (3) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      total_cnt++;
      if (m_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", m_tvalid); else pass_cnt++;
      total_cnt++;
      if (m_tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", m_tlast); else pass_cnt++;
      total_cnt++;
      if (m_tkeep !== 8'h00) $display("FAIL rst_tkeep: got %h want 00", m_tkeep); else pass_cnt++;
      total_cnt++;
      if (m_tdata !== 64'h0) $display("FAIL rst_tdata: got %h want 0", m_tdata); else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++;
      if ({drop_err, mode_err} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {drop_err, mode_err});
      else pass_cnt++;
      total_cnt++;
      if (din_ready !== 1'b1) $display("FAIL rst_din_ready: got %b want 1", din_ready); else pass_cnt++;
   endtask

   task automatic test_sha256();
      logic [DW-1:0] d;
      logic [63:0] first;
`ifdef DIGEST_STREAM_TX_BSWAP_EN
      first = 64'hEACF018FBF1678BA;
`else
      first = 64'hBA7816BF8F01CFEA;
`endif
      d = rand_digest();
      d[DW-1 -: 256] = 256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD;
      clear_q();
      push_exp(d, 4'h0);
      ready_mode = 0;
      m_tready = 1'b1;
      capture(d, 4'h0);
      total_cnt++;
      if (m_tvalid !== 1'b1 || busy !== 1'b1)
         $display("FAIL sha256_t1: got valid=%b busy=%b want 1 1", m_tvalid, busy);
      else pass_cnt++;
      total_cnt++;
      if (m_tdata !== first || m_tkeep !== 8'hFF)
         $display("FAIL sha256_first: got %h/%h want %h/ff", m_tdata, m_tkeep, first);
      else pass_cnt++;
      drain(40);
      total_cnt++;
      if (rx_q.size() != exp_q.size())
         $display("FAIL sha256_count: got %0d want %0d", rx_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         total_cnt++;
         if (rx_q[i] !== exp_q[i]) $display("FAIL sha256_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (rx_q.size() == 4 && (rx_q[3][72:64] !== 9'h1FF || rx_cyc[3] - rx_cyc[0] != 3))
         $display("FAIL sha256_last: got last/keep=%h span=%0d want 1ff span 3",
                  rx_q[3][72:64], rx_cyc[3] - rx_cyc[0]);
      else pass_cnt++;
   endtask

   task automatic test_sha3_224_bp();
      logic [DW-1:0] d;
      logic [7:0] keep_exp;
      logic [31:0] pad;
      d = rand_digest();
      clear_q();
      push_exp(d, 4'hC);
      ready_mode = 1;
      stab_viol = 0;
      capture(d, 4'hC);
      drain(80);
      ready_mode = 0;
      m_tready = 1'b1;
      total_cnt++;
      if (rx_q.size() != 4) $display("FAIL sha3_224_count: got %0d want 4", rx_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         total_cnt++;
         if (rx_q[i] !== exp_q[i]) $display("FAIL sha3_224_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]);
         else pass_cnt++;
      end
`ifdef DIGEST_STREAM_TX_BSWAP_EN
      keep_exp = 8'h0F;
      pad = (rx_q.size() == 4) ? rx_q[3][63:32] : 32'hFFFFFFFF;
`else
      keep_exp = 8'hF0;
      pad = (rx_q.size() == 4) ? rx_q[3][31:0] : 32'hFFFFFFFF;
`endif
      total_cnt++;
      if (rx_q.size() != 4 || rx_q[3][71:64] !== keep_exp || pad !== 32'h0)
         $display("FAIL sha3_224_tail: got keep=%h pad=%h want %h 0",
                  rx_q.size() == 4 ? rx_q[3][71:64] : 8'hXX, pad, keep_exp);
      else pass_cnt++;
      total_cnt++;
      if (stab_viol != 0) $display("FAIL sha3_224_stable: got %0d violations want 0", stab_viol);
      else pass_cnt++;
      total_cnt++;
      if (rx_q.size() == 4 && rx_cyc[3] - rx_cyc[0] <= 3)
         $display("FAIL sha3_224_stalls: got span %0d want >3", rx_cyc[3] - rx_cyc[0]);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] d1;
      logic [DW-1:0] d2;
      int lasts;
      d1 = rand_digest();
      d2 = rand_digest();
      clear_q();
      push_exp(d1, 4'h8);
      push_exp(d2, 4'h9);
      ready_mode = 0;
      m_tready = 1'b1;
      capture(d1, 4'h8);
      repeat (20) step();
      din = d2;
      algo_mode = 4'h9;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      total_cnt++;
      if (s_ready !== 1'b1) $display("FAIL b2b_din_ready: got %b want 1", s_ready); else pass_cnt++;
      drain(60);
      total_cnt++;
      if (rx_q.size() != 38) $display("FAIL b2b_count: got %0d want 38", rx_q.size()); else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         total_cnt++;
         if (rx_q[i] !== exp_q[i]) $display("FAIL b2b_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]);
         else pass_cnt++;
      end
      lasts = 0;
      foreach (rx_q[i]) if (rx_q[i][72]) lasts++;
      total_cnt++;
      if (rx_q.size() != 38 || rx_cyc[37] - rx_cyc[0] != 37 || lasts != 2)
         $display("FAIL b2b_gapless: got %0d beats, %0d lasts want 38 beats in 38 cycles, 2 lasts",
                  rx_q.size(), lasts);
      else pass_cnt++;
   endtask

   task automatic test_errors();
      logic [DW-1:0] d1;
      d1 = rand_digest();
      clear_q();
      push_exp(d1, 4'h0);
      ready_mode = 3;
      m_tready = 1'b0;
      capture(d1, 4'h0);
      repeat (2) step();
      din = rand_digest();
      algo_mode = 4'h1;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      total_cnt++;
      if (s_ready !== 1'b0 || drop_err !== 1'b1 || mode_err !== 1'b0 || busy !== 1'b1)
         $display("FAIL drop_flag: got ready=%b drop=%b mode=%b busy=%b want 0 1 0 1",
                  s_ready, drop_err, mode_err, busy);
      else pass_cnt++;
      ready_mode = 0;
      m_tready = 1'b1;
      drain(40);
      total_cnt++;
      if (rx_q.size() != 4) $display("FAIL drop_count: got %0d want 4", rx_q.size()); else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         total_cnt++;
         if (rx_q[i] !== exp_q[i]) $display("FAIL drop_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]);
         else pass_cnt++;
      end
      capture(rand_digest(), 4'hF);
      total_cnt++;
      if (mode_err !== 1'b1 || drop_err !== 1'b1 || busy !== 1'b0 || m_tvalid !== 1'b0)
         $display("FAIL mode_flag: got mode=%b drop=%b busy=%b valid=%b want 1 1 0 0",
                  mode_err, drop_err, busy, m_tvalid);
      else pass_cnt++;
      clr_err = 1'b1;
      din_valid = 1'b1;
      algo_mode = 4'hE;
      step();
      din_valid = 1'b0;
      clr_err = 1'b0;
      total_cnt++;
      if (mode_err !== 1'b1 || drop_err !== 1'b0)
         $display("FAIL clr_set_wins: got mode=%b drop=%b want 1 0", mode_err, drop_err);
      else pass_cnt++;
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      total_cnt++;
      if ({drop_err, mode_err} !== 2'b00 || busy !== 1'b0)
         $display("FAIL clr_flags: got %b busy=%b want 00 0", {drop_err, mode_err}, busy);
      else pass_cnt++;
      repeat (3) step();
      total_cnt++;
      if (rx_q.size() != 4) $display("FAIL mode_no_stream: got %0d beats want 4", rx_q.size());
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] d;
      int lasts;
      clear_q();
      ready_mode = 0;
      m_tready = 1'b1;
      capture(rand_digest(), 4'h1);
      repeat (2) step();
      ready_mode = 3;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      total_cnt++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0)
         $display("FAIL rstmid_idle: got valid=%b busy=%b want 0 0", m_tvalid, busy);
      else pass_cnt++;
      ready_mode = 0;
      repeat (3) step();
      lasts = 0;
      foreach (rx_q[i]) if (rx_q[i][72]) lasts++;
      total_cnt++;
      if (rx_q.size() != 3 || lasts != 0)
         $display("FAIL rstmid_partial: got %0d beats %0d lasts want 3 0", rx_q.size(), lasts);
      else pass_cnt++;
      d = rand_digest();
      clear_q();
      push_exp(d, 4'h1);
      capture(d, 4'h1);
      drain(40);
      total_cnt++;
      if (rx_q.size() != 8) $display("FAIL rstmid_count: got %0d want 8", rx_q.size()); else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         total_cnt++;
         if (rx_q[i] !== exp_q[i]) $display("FAIL rstmid_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] d;
      logic [3:0] m;
      clear_q();
      ready_mode = 2;
      stab_viol = 0;
      for (int t = 0; t < 20; t++) begin
         d = rand_digest();
         m = 4'($urandom_range(0, 13));
         push_exp(d, m);
         capture(d, m);
         drain(200);
      end
      ready_mode = 0;
      m_tready = 1'b1;
      total_cnt++;
      if (rx_q.size() != exp_q.size())
         $display("FAIL rand_count: got %0d want %0d", rx_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         total_cnt++;
         if (rx_q[i] !== exp_q[i]) $display("FAIL rand_beat%0d: got %h want %h", i, rx_q[i], exp_q[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (stab_viol != 0) $display("FAIL rand_stable: got %0d violations want 0", stab_viol);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_sha256();
      test_sha3_224_bp();
      test_back_to_back();
      test_errors();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion (%0d/%0d so far)", pass_cnt, total_cnt);
      $fatal(1);
   end

endmodule

// File: doc/digest_stream_tx.md
Name: digest_stream_tx

Overview:
- Reader/transmitter for the shared hash output of the SHA2/SHAKE top.
- Captures one 1344-bit `dout` digest word when `dout_valid` is high, together with the algorithm mode.
- Serialises the mode-dependent number of digest bytes onto a 64-bit AXI-Stream master (`tvalid`/`tready`/`tlast`/`tkeep`) for DMA or host readout.
- Reports dropped digests and illegal modes through sticky flags.

Parameters:
- DW, 1344: width of the captured digest vector.
- OW, 64: output stream data width. Only 64 is supported; `tkeep` is OW/8 bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- algo_mode  in  4  same encoding as the hash top; sampled on capture.
- din  in  1344  digest vector, first byte at din[1343:1336], left-aligned.
- din_valid  in  1  digest strobe, single cycle; no backpressure at the source.
- din_ready  out  1  capture possible this cycle.
- m_tvalid  out  1  stream beat valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  64  stream data.
- m_tkeep  out  8  byte enables.
- m_tlast  out  1  final beat of a digest.
- busy  out  1  a digest is held or being sent.
- drop_err  out  1  sticky: `din_valid` arrived while `din_ready` was 0; that digest is discarded.
- mode_err  out  1  sticky: capture with an illegal mode; that digest is discarded.
- clr_err  in  1  clears both sticky flags; a set event in the same cycle wins.

Behaviour:
- Reset values:
  - m_tvalid = 0, m_tlast = 0, m_tkeep = 0, m_tdata = 0.
  - busy = 0, drop_err = 0, mode_err = 0.
  - State = IDLE, beat counter = 0.
- `din_ready` = (state == IDLE) | (m_tvalid & m_tready & m_tlast). This is combinational and allows back-to-back digests with zero bubble.
- Byte length N, decoded from `algo_mode` at capture:
  - 0x0 (SHA-256) = 32; 0x1 (SHA-512) = 64.
  - SHA2 with algo_mode[2:1] != 0 still decodes on bit 0 only.
  - 0x8 (SHAKE128) = 168; 0x9 (SHAKE256) = 136.
  - 0xA (SHA3-256) = 32; 0xB (SHA3-512) = 64.
  - 0xC (SHA3-224) = 28; 0xD (SHA3-384) = 48.
  - 0xE and 0xF are illegal: set mode_err, no capture, state unchanged.
- Beat count = ceil(N/8), range 4..21. The counter is 5 bits.
- Capture (din_valid & din_ready & legal mode) at edge T:
  - Latch `din` into the shift buffer and latch the beat count.
  - State becomes SEND; m_tvalid = 1 from T+1.
- States:
  - IDLE: waits for capture.
  - SEND: presents beat k = buf[1343:1280].
    - On m_tvalid & m_tready: shift the buffer left by 64 and increment k.
    - On the last beat handshake: go to IDLE, or stay in SEND if a new capture occurs in that same cycle, reloading the buffer and counter.
- AXI rules:
  - m_tvalid is never deasserted without a handshake.
  - m_tdata, m_tkeep and m_tlast are stable while m_tvalid & !m_tready.
  - m_tvalid does not depend on m_tready.
- m_tlast is 1 only on beat ceil(N/8)-1.
- m_tkeep:
  - 8'hFF on all non-last beats.
  - On the last beat, the top (N mod 8) lanes; 8'hFF if N mod 8 = 0.
  - SHA3-224 last beat = 8'hF0, with m_tdata[31:0] driven 0.
- busy = (state == SEND).
- `din_valid` while `din_ready` = 0: the new digest is ignored, drop_err is set, and the transfer in progress is unaffected.
- rst mid-transfer: next cycle m_tvalid = 0 and state = IDLE. The partial digest is abandoned; no m_tlast is emitted.

Optional Feature:
- Macro DIGEST_STREAM_TX_BSWAP_EN.
- Defined:
  - Lane order within each beat is little-endian: first stream byte is on m_tdata[7:0].
  - The last-beat m_tkeep uses the low lanes; SHA3-224 last beat = 8'h0F with m_tdata[63:32] = 0.
- Undefined (default):
  - Big-endian order: first byte on m_tdata[63:56], as described above.
- Beat count, timing and flags are identical in both builds.

Test Plan:
- SHA-256: algo_mode=0x0, din[1343:1088]=0xBA7816BF…F20015AD (SHA-256("abc")), m_tready=1 -> 4 beats starting T+1; first m_tdata=0xBA7816BF8F01CFEA; beat 3 has m_tlast=1, m_tkeep=8'hFF.
- SHA3-224 with backpressure: algo_mode=0xC, m_tready toggling 1010… -> 4 beats; data held stable during stalls; last beat m_tkeep=8'hF0, m_tdata[31:0]=0.
- SHAKE128 back-to-back: mode 0x8 capture, second din_valid with mode 0x9 in the same cycle as the 21st beat handshake -> din_ready=1 that cycle; 21 beats then 17 beats with no idle cycle between; two m_tlast pulses.
- Drop and mode errors: din_valid during SEND -> drop_err=1, current stream unchanged. Then algo_mode=0xF capture -> mode_err=1, busy stays 0. Then clr_err -> both flags 0 next cycle.
- Reset mid-transfer: rst on beat 3 of a SHA-512 digest -> m_tvalid=0, busy=0 next cycle, no m_tlast. A following SHA-512 capture produces a full 8 beats.
- BSWAP build: repeat the SHA-256 case -> first m_tdata=0xEACF018FBF1678BA, m_tkeep=8'hFF; SHA3-224 last m_tkeep=8'h0F.
